multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- One ALU, one register file and one datapath are shared across FETCH/DECODE/EXEC/MEM/WB states, under an internal FSM controller.
- Instruction and data memories are internal.
- Instruction memory is loadable through a write port.
- Provides a register debug read port, a retired-instruction counter and a halt indication for bench and on-board observation.

Parameters:
DATA_WIDTH, 32, register/ALU/data-memory word width (16..32); immediates sign-extended to this width
REG_ADDR_W, 5, register-file address bits (2**REG_ADDR_W registers, max 5); rs/rt/rd fields truncated to low REG_ADDR_W bits
IMEM_DEPTH, 256, instruction words (power of 2)
DMEM_DEPTH, 256, data words (power of 2)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
ImemWe  input  1  instruction-memory write enable
ImemAddr  input  $clog2(IMEM_DEPTH)  instruction word index for load
ImemWData  input  32  instruction word to load
DbgAddr  input  REG_ADDR_W  debug register select
DbgData  output  DATA_WIDTH  combinational read of register DbgAddr
PC  output  32  byte program counter
WriteData  output  DATA_WIDTH  value of last register-file write
RetireCount  output  32  instructions completed since reset
Halted  output  1  high while in HALT state

Behaviour:
- Reset (synchronous) clears to zero:
  - PC, IR, A, B, ALUOut, MDR
  - all registers
  - WriteData, RetireCount, Halted
  - FSM to FETCH
  - Data and instruction memories are NOT cleared.
- Reset wins over every other event, including mid-instruction: partial effects already committed stay committed, nothing further.
- Register 0 always reads 0; writes to it are discarded (WriteData still updates).
- Imem write is synchronous on ImemWe, independent of FSM state. It is legal only while Reset is high or Halted; behaviour otherwise is undefined for the bench.
- PC is a byte address. Imem index = PC[2+:log2(IMEM_DEPTH)]. Dmem index = ALUOut[2+:log2(DMEM_DEPTH)]. Both wrap silently.
- Supported instructions:
  - R-type (op 0), by funct: add 20h, sub 22h, and 24h, or 25h, slt 2Ah (signed), sll 00h (shamt)
  - addi 08h, lw 23h, sw 2Bh, beq 04h, j 02h, halt 3Fh
  - Any other op/funct executes as NOP (4 cycles, retires).
- FSM states and actions:
  - FETCH: IR<=imem[PC]; PC<=PC+4.
  - DECODE: A<=R[rs]; B<=R[rt]; ALUOut<=PC+(signext(imm)<<2) (branch target). Then:
    - j: PC<={PC[31:28],target,2'b00}; retire; to FETCH.
    - halt: to HALT, Halted<=1, retire.
    - else: to EXEC.
  - EXEC:
    - R-type: ALUOut<=A op B (sll: B<<shamt).
    - addi/lw/sw: ALUOut<=A+signext(imm).
    - beq: if A==B PC<=ALUOut; retire; to FETCH.
  - MEM:
    - lw: MDR<=dmem[idx]; to WB.
    - sw: dmem[idx]<=B; retire; to FETCH.
  - WB: R[dest]<=value; WriteData<=value; retire; to FETCH.
    - dest = rd for R-type, rt for addi/lw.
    - value = ALUOut, or MDR for lw.
    - R-type/addi/NOP skip MEM (EXEC->WB). NOP writes nothing and retires in WB.
  - HALT: hold all state; leave only via Reset.
- Cycle counts:
  - j, halt: 2
  - beq: 3
  - R-type, addi, sw, NOP: 4
  - lw: 5
- Arithmetic is DATA_WIDTH-bit two's complement; overflow wraps with no trap. The PC adder is 32-bit and wraps at 2^32.
- RetireCount increments by 1 on the retire cycle and wraps at 2^32.

Test Plan:
- Reset, load imem[0]=addi $8,$0,5 then halt -> after 2 cycles in FETCH, DbgData(8)=5 at cycle 4; Halted=1 at cycle 6; RetireCount=2; PC=8.
- add/sub/slt: $16=7, $17=-3 via addi; add $18,$16,$17; slt $19,$17,$16 -> $18=4, $19=1, WriteData=1.
- sw $16,4($0) then lw $8,4($0) -> $8=7; lw takes exactly 5 cycles; dmem[1]=7.
- beq $0,$0,-1 before halt -> loop: PC stays 0x0, RetireCount +1 every 3 cycles. Then assert Reset for 1 cycle mid-EXEC -> all outputs 0, FSM in FETCH next cycle.
- addi $0,$0,9 -> DbgData(0)=0, WriteData=9. With DATA_WIDTH=16: addi $8,$0,-1 then add $8,$8,$8 -> $8=16'hFFFE.
- j 0x10 at PC 0 -> next fetch at 0x40. Unknown op 3Eh -> NOP: 4 cycles, no register change, RetireCount increments.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS subset processor.
// A single ALU, register file and datapath are time-shared across the
// FETCH/DECODE/EXEC/MEM/WB steps under a small FSM. Instruction and data
// memories live inside the core; the instruction memory has a load port.
module multicycle_core #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          ImemWe,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ImemAddr,
    input  logic [31:0]                   ImemWData,
    input  logic [REG_ADDR_W-1:0]         DbgAddr,
    output logic [DATA_WIDTH-1:0]         DbgData,
    output logic [31:0]                   PC,
    output logic [DATA_WIDTH-1:0]         WriteData,
    output logic [31:0]                   RetireCount,
    output logic                          Halted
);

    localparam int IMEM_AW  = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW  = $clog2(DMEM_DEPTH);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Architectural and inter-step registers
    state_t                state_q;
    logic [31:0]           pc_q;
    logic [31:0]           ir_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] aluOut_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] writeData_q;
    logic [31:0]           retire_q;
    logic                  halted_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Memories (never cleared by reset)
    logic [31:0]           imem_q [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] dmem_q [DMEM_DEPTH];

    // Instruction fields, decoded from the held instruction register
    logic [5:0]            op;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            shamt;
    logic [15:0]           immField;
    logic [25:0]           jumpField;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[21 +: REG_ADDR_W];
    assign rt        = ir_q[16 +: REG_ADDR_W];
    assign rd        = ir_q[11 +: REG_ADDR_W];
    assign shamt     = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign immField  = ir_q[15:0];
    assign jumpField = ir_q[25:0];

    // Derived datapath values
    logic [DATA_WIDTH-1:0] immExt;
    logic [31:0]           branchOffset;
    logic [31:0]           pcPlus4;
    logic [31:0]           branchTarget;
    logic [31:0]           jumpTarget;
    logic [IMEM_AW-1:0]    imemIdx;
    logic [DMEM_AW-1:0]    dmemIdx;
    logic                  isKnownR;
    logic                  writesReg;
    logic [REG_ADDR_W-1:0] wbDest;
    logic [DATA_WIDTH-1:0] wbValue;
    logic [DATA_WIDTH-1:0] aluResult_d;
    logic                  dmemWe;

    assign immExt       = DATA_WIDTH'($signed(immField));
    assign branchOffset = (32'($signed(immField))) << 2;
    assign pcPlus4      = pc_q + 32'd4;
    assign branchTarget = pc_q + branchOffset;
    assign jumpTarget   = {pc_q[31:28], jumpField, 2'b00};
    assign imemIdx      = pc_q[2 +: IMEM_AW];
    assign dmemIdx      = aluOut_q[2 +: DMEM_AW];

    assign writesReg = isKnownR || (op == OP_ADDI) || (op == OP_LW);
    assign wbDest    = (op == OP_RTYPE) ? rd : rt;
    assign wbValue   = (op == OP_LW) ? mdr_q : aluOut_q;

    // Stores commit in MEM; reset suppresses a store in its cycle
    assign dmemWe = !Reset && (state_q == S_MEM) && (op == OP_SW);

    // Classify R-type function codes; unknown ones behave as NOP
    always_comb begin
        isKnownR = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: isKnownR = 1'b1;
                default:                                       isKnownR = 1'b0;
            endcase
        end
    end

    // Shared ALU: R-type operations, otherwise base + sign-extended offset
    always_comb begin
        aluResult_d = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  aluResult_d = a_q + b_q;
                FN_SUB:  aluResult_d = a_q - b_q;
                FN_AND:  aluResult_d = a_q & b_q;
                FN_OR:   aluResult_d = a_q | b_q;
                FN_SLT:  aluResult_d = DATA_WIDTH'($signed(a_q) < $signed(b_q));
                FN_SLL:  aluResult_d = b_q << shamt;
                default: aluResult_d = '0;
            endcase
        end else begin
            aluResult_d = a_q + immExt;
        end
    end

    // Instruction memory load port, usable while in reset or halted
    always_ff @(posedge Clock) begin
        if (ImemWe) begin
            imem_q[ImemAddr] <= ImemWData;
        end
    end

    // Data memory write port driven by store instructions
    always_ff @(posedge Clock) begin
        if (dmemWe) begin
            dmem_q[dmemIdx] <= b_q;
        end
    end

    // Controller and datapath registers: one step of the instruction per cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluOut_q    <= '0;
            mdr_q       <= '0;
            writeData_q <= '0;
            retire_q    <= '0;
            halted_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= imem_q[imemIdx];
                    pc_q    <= pcPlus4;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q      <= regs_q[rs];
                    b_q      <= regs_q[rt];
                    aluOut_q <= branchTarget[DATA_WIDTH-1:0];
                    if (op == OP_J) begin
                        pc_q     <= jumpTarget;
                        retire_q <= retire_q + 32'd1;
                        state_q  <= S_FETCH;
                    end else if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        retire_q <= retire_q + 32'd1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_BEQ) begin
                        if (a_q == b_q) begin
                            pc_q <= 32'(aluOut_q);
                        end
                        retire_q <= retire_q + 32'd1;
                        state_q  <= S_FETCH;
                    end else begin
                        aluOut_q <= aluResult_d;
                        if ((op == OP_LW) || (op == OP_SW)) begin
                            state_q <= S_MEM;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        mdr_q   <= dmem_q[dmemIdx];
                        state_q <= S_WB;
                    end else begin
                        retire_q <= retire_q + 32'd1;
                        state_q  <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (writesReg) begin
                        if (wbDest != '0) begin
                            regs_q[wbDest] <= wbValue;
                        end
                        writeData_q <= wbValue;
                    end
                    retire_q <= retire_q + 32'd1;
                    state_q  <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign DbgData     = regs_q[DbgAddr];
    assign PC          = pc_q;
    assign WriteData   = writeData_q;
    assign RetireCount = retire_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and randomized programs for multicycle_core,
// compared against an instruction-level model of the processor.
module tb_multicycle_core;

    logic        Clock;
    logic        Reset;
    logic        ImemWe;
    logic [7:0]  ImemAddr;
    logic [31:0] ImemWData;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgData;
    logic [31:0] PC;
    logic [31:0] WriteData;
    logic [31:0] RetireCount;
    logic        Halted;

    logic [15:0] dbgData16;
    logic [31:0] pc16;
    logic [15:0] writeData16;
    logic [31:0] retire16;
    logic        halted16;

    int checks = 0;
    int errors = 0;

    multicycle_core dut (
        .Clock(Clock), .Reset(Reset), .ImemWe(ImemWe), .ImemAddr(ImemAddr),
        .ImemWData(ImemWData), .DbgAddr(DbgAddr), .DbgData(DbgData), .PC(PC),
        .WriteData(WriteData), .RetireCount(RetireCount), .Halted(Halted)
    );

    multicycle_core #(.DATA_WIDTH(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .ImemWe(ImemWe), .ImemAddr(ImemAddr),
        .ImemWData(ImemWData), .DbgAddr(DbgAddr), .DbgData(dbgData16), .PC(pc16),
        .WriteData(writeData16), .RetireCount(retire16), .Halted(halted16)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Instruction-level model state
    logic [31:0] mImem [256];
    logic [31:0] mDmem [256];
    logic [31:0] mRegs [32];
    logic [31:0] mPc;
    logic [31:0] mRetire;
    logic [31:0] mWd;
    logic        mHalt;
    logic [31:0] progQ [$];

    function automatic logic [31:0] rType(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] iType(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jType(int target);
        return {6'h02, 26'(target)};
    endfunction

    function automatic logic [31:0] haltInstr();
        return {6'h3F, 26'h0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic resetModel();
        mPc = 0;
        mRetire = 0;
        mWd = 0;
        mHalt = 1'b0;
        for (int r = 0; r < 32; r++) mRegs[r] = 0;
    endtask

    // Executes one instruction of the model; returns its cycle cost
    task automatic modelStep(output int cyc);
        logic [31:0] ir, pcp4, sx, val, addr, a, b;
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh, dest;
        bit          wr;
        ir = mImem[mPc[9:2]];
        pcp4 = mPc + 32'd4;
        op = ir[31:26];
        fn = ir[5:0];
        rs = int'(ir[25:21]);
        rt = int'(ir[20:16]);
        rd = int'(ir[15:11]);
        sh = int'(ir[10:6]);
        sx = {{16{ir[15]}}, ir[15:0]};
        a = mRegs[rs];
        b = mRegs[rt];
        addr = a + sx;
        wr = 0;
        dest = 0;
        val = 0;
        cyc = 4;
        mPc = pcp4;
        case (op)
            6'h02: begin mPc = {pcp4[31:28], ir[25:0], 2'b00}; cyc = 2; end
            6'h3F: begin mHalt = 1'b1; cyc = 2; end
            6'h04: begin cyc = 3; if (a == b) mPc = pcp4 + (sx << 2); end
            6'h08: begin wr = 1; dest = rt; val = addr; end
            6'h23: begin cyc = 5; wr = 1; dest = rt; val = mDmem[addr[9:2]]; end
            6'h2B: mDmem[addr[9:2]] = b;
            6'h00: begin
                wr = 1;
                dest = rd;
                case (fn)
                    6'h20: val = a + b;
                    6'h22: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: val = b << sh;
                    default: wr = 0;
                endcase
            end
            default: ;
        endcase
        if (wr) begin
            mWd = val;
            if (dest != 0) mRegs[dest] = val;
        end
        mRetire = mRetire + 32'd1;
    endtask

    // Loads progQ into instruction memory under reset, then checks reset state and releases reset
    task automatic applyStimulus();
        Reset = 1'b1;
        foreach (progQ[i]) begin
            @(negedge Clock);
            ImemWe = 1'b1;
            ImemAddr = 8'(i);
            ImemWData = progQ[i];
            mImem[i] = progQ[i];
        end
        @(negedge Clock);
        ImemWe = 1'b0;
        DbgAddr = 5'd9;
        #1;
        checkOutput("rstPc", PC, 32'h0);
        checkOutput("rstRetire", RetireCount, 32'h0);
        checkOutput("rstWriteData", WriteData, 32'h0);
        checkOutput("rstHalted", {31'b0, Halted}, 32'h0);
        checkOutput("rstReg9", DbgData, 32'h0);
        resetModel();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic runInstr();
        int          cyc;
        logic [31:0] prevRetire;
        prevRetire = mRetire;
        modelStep(cyc);
        tick(cyc - 1);
        checkOutput("retireEarly", RetireCount, prevRetire);
        tick(1);
        checkOutput("pc", PC, mPc);
        checkOutput("retire", RetireCount, mRetire);
        checkOutput("writeData", WriteData, mWd);
        checkOutput("halted", {31'b0, Halted}, {31'b0, mHalt});
    endtask

    task automatic checkRegs();
        for (int r = 0; r < 32; r++) begin
            DbgAddr = 5'(r);
            #1;
            checkOutput($sformatf("reg%0d", r), DbgData, mRegs[r]);
        end
    endtask

    // Runs until the model halts (bounded), then confirms the core holds still
    task automatic runProgram();
        int steps = 0;
        while (!mHalt && steps < 200) begin
            runInstr();
            steps++;
        end
        checkOutput("haltReached", {31'b0, mHalt}, 32'h1);
        tick(3);
        checkOutput("holdPc", PC, mPc);
        checkOutput("holdRetire", RetireCount, mRetire);
        checkOutput("holdHalted", {31'b0, Halted}, 32'h1);
        checkRegs();
    endtask

    task automatic genRandomProgram();
        int kind, idx;
        progQ.delete();
        for (int k = 0; k < 8; k++) progQ.push_back(iType(8'h2B, 0, 0, 4 * k));
        for (int n = 0; n < 20; n++) begin
            idx = 8 + n;
            kind = int'($urandom_range(0, 11));
            case (kind)
                0, 1: progQ.push_back(iType(8'h08, int'($urandom_range(0, 15)),
                                            int'($urandom_range(1, 15)), int'($urandom_range(0, 65535))));
                2: progQ.push_back(rType(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                         int'($urandom_range(0, 15)), 0, 8'h20));
                3: progQ.push_back(rType(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                         int'($urandom_range(0, 15)), 0, 8'h22));
                4: progQ.push_back(rType(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                         int'($urandom_range(0, 15)), 0,
                                         ($urandom_range(0, 1) == 0) ? 8'h24 : 8'h25));
                5: progQ.push_back(rType(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                         int'($urandom_range(0, 15)), 0, 8'h2A));
                6: progQ.push_back(rType(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                         int'($urandom_range(0, 31)), 8'h00));
                7: progQ.push_back(iType(8'h2B, 0, int'($urandom_range(0, 15)), 4 * int'($urandom_range(0, 7))));
                8: progQ.push_back(iType(8'h23, 0, int'($urandom_range(1, 15)), 4 * int'($urandom_range(0, 7))));
                9: progQ.push_back(iType(8'h04, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                         int'($urandom_range(0, 2))));
                10: progQ.push_back(jType(idx + 1 + int'($urandom_range(0, 2))));
                default: progQ.push_back(iType(8'h3E, 1, 2, 3));
            endcase
        end
        for (int k = 0; k < 4; k++) progQ.push_back(haltInstr());
    endtask

    initial begin
        Reset = 1'b1;
        ImemWe = 1'b0;
        ImemAddr = '0;
        ImemWData = '0;
        DbgAddr = '0;

        // addi then halt
        progQ = {iType(8'h08, 0, 8, 5), haltInstr()};
        applyStimulus();
        runInstr();
        DbgAddr = 5'd8;
        #1;
        checkOutput("addiReg8", DbgData, 32'd5);
        runInstr();
        checkOutput("haltPc", PC, 32'd8);
        checkOutput("haltRetire", RetireCount, 32'd2);
        runProgram();

        // arithmetic, store/load, write to $0
        progQ = {iType(8'h08, 0, 16, 7), iType(8'h08, 0, 17, -3),
                 rType(16, 17, 18, 0, 8'h20), rType(16, 17, 20, 0, 8'h22),
                 rType(17, 16, 19, 0, 8'h2A), iType(8'h2B, 0, 16, 4),
                 iType(8'h23, 0, 8, 4), iType(8'h08, 0, 0, 9), haltInstr()};
        applyStimulus();
        repeat (5) runInstr();
        checkOutput("sltWriteData", WriteData, 32'd1);
        runProgram();
        checkOutput("lastWriteData", WriteData, 32'd9);
        DbgAddr = 5'd18; #1; checkOutput("addReg18", DbgData, 32'd4);
        DbgAddr = 5'd19; #1; checkOutput("sltReg19", DbgData, 32'd1);
        DbgAddr = 5'd8;  #1; checkOutput("lwReg8", DbgData, 32'd7);
        DbgAddr = 5'd0;  #1; checkOutput("zeroReg", DbgData, 32'd0);

        // branch loop interrupted by reset in EXEC
        progQ = {iType(8'h08, 0, 9, 3), iType(8'h04, 0, 0, -1), haltInstr()};
        applyStimulus();
        runInstr();
        repeat (4) runInstr();
        checkOutput("loopPc", PC, 32'h4);
        tick(2);
        Reset = 1'b1;
        DbgAddr = 5'd9;
        tick(1);
        #1;
        checkOutput("midPc", PC, 32'h0);
        checkOutput("midRetire", RetireCount, 32'h0);
        checkOutput("midWriteData", WriteData, 32'h0);
        checkOutput("midHalted", {31'b0, Halted}, 32'h0);
        checkOutput("midReg9", DbgData, 32'h0);
        resetModel();
        Reset = 1'b0;
        runInstr();
        runInstr();

        // jump over filler to a NOP then halt
        progQ.delete();
        progQ.push_back(jType(32'h10));
        for (int k = 1; k < 16; k++) progQ.push_back(iType(8'h08, 0, 10, 1));
        progQ.push_back(iType(8'h3E, 1, 2, 3));
        progQ.push_back(haltInstr());
        applyStimulus();
        runInstr();
        checkOutput("jumpPc", PC, 32'h40);
        runProgram();

        // 16-bit width wrap
        progQ = {iType(8'h08, 0, 8, -1), rType(8, 8, 8, 0, 8'h20), haltInstr()};
        applyStimulus();
        runProgram();
        DbgAddr = 5'd8;
        #1;
        checkOutput("w16Reg8", {16'h0, dbgData16}, 32'h0000FFFE);
        checkOutput("w16WriteData", {16'h0, writeData16}, 32'h0000FFFE);
        checkOutput("w16Pc", pc16, 32'd12);
        checkOutput("w16Retire", retire16, 32'd3);
        checkOutput("w16Halted", {31'b0, halted16}, 32'h1);

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            genRandomProgram();
            applyStimulus();
            runProgram();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
